// File: rtl/stepper_ramp_controller.sv
// Purpose    : unipolar stepper sequencer with a linear accel/cruise/decel ramp on the step period.
// Latency    : first step cur_div cycles after the accept edge; done pulses on the edge of the final step or of an abort.
// Backpressure: cmd_ready is high only while idle; cmd_valid is ignored during a move.
//
// Ports:
//   in_clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (accepted when both high)
//   cmd_steps, cmd_dir              step count, direction (1 = phase index up)
//   cmd_start_div, cmd_run_div      start/stop and cruise step periods in in_clk cycles
//   half_step                       sampled at accept: 1 = half-step, 0 = full-step
//   abort                           stop the move on the next edge
//   coils                           coil drive {A,B,C,D}, held between moves
//   busy, done                      move in progress, one-cycle end-of-move pulse
//   steps_left, cur_div             remaining steps, current step period
module stepper_ramp_controller #(
    parameter int DIV_W       = 16,
    parameter int STEP_W      = 16,
    parameter int ACCEL_DELTA = 20
) (
    input  logic              in_clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic [DIV_W-1:0]  cmd_start_div,
    input  logic [DIV_W-1:0]  cmd_run_div,
    input  logic              half_step,
    input  logic              abort,
    output logic [3:0]        coils,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left,
    output logic [DIV_W-1:0]  cur_div
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2,
        ST_DECEL  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0]  DELTA   = DIV_W'(ACCEL_DELTA);
    localparam logic [DIV_W-1:0]  ONE_D   = 1;
    localparam logic [STEP_W-1:0] ONE_S   = 1;
    localparam logic [STEP_W:0]   ONE_S_W = 1;

    // Phase index -> coil pattern {A,B,C,D}; odd indices are the two-coil full steps.
    function automatic logic [3:0] phase_pat(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        phase_q, phase_d;
    logic [STEP_W-1:0] ramp_q, ramp_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  cur_div_q, cur_div_d;
    logic [DIV_W-1:0]  start_div_q, start_div_d;
    logic [DIV_W-1:0]  run_div_q, run_div_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;
    logic [3:0]        coils_q, coils_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dir_q, dir_d;
    logic              half_q, half_d;
    logic              cmd_ready_q, cmd_ready_d;

    // Command sanitising: zero periods become 1, cruise never slower than start.
    logic [DIV_W-1:0]  start_eff, run_nz, run_eff;
    assign start_eff = (cmd_start_div == '0) ? ONE_D : cmd_start_div;
    assign run_nz    = (cmd_run_div == '0) ? ONE_D : cmd_run_div;
    assign run_eff   = (run_nz > start_eff) ? start_eff : run_nz;

    logic              step_fire;
    logic [STEP_W-1:0] steps_new;
    logic [2:0]        phase_inc, phase_nxt;
    logic              accel_near_end, cruise_near_end, accel_room;
    logic [DIV_W-1:0]  decel_div;

    assign step_fire = (cnt_q == cur_div_q - ONE_D);
    assign steps_new = steps_left_q - ONE_S;

    // An even index in full-step mode takes a single half step to land on an odd index.
    assign phase_inc = (half_q || !phase_q[0]) ? 3'd1 : 3'd2;
    assign phase_nxt = dir_q ? (phase_q + phase_inc) : (phase_q - phase_inc);

    // Differences are taken only in the direction that cannot wrap:
    // run_div <= cur_div <= start_div holds throughout a move.
    assign accel_room      = (cur_div_q - run_div_q) > DELTA;
    assign decel_div       = ((start_div_q - cur_div_q) > DELTA) ? (cur_div_q + DELTA) : start_div_q;
    assign accel_near_end  = {1'b0, steps_new} <= ({1'b0, ramp_q} + ONE_S_W);
    assign cruise_near_end = steps_new <= ramp_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        ramp_d       = ramp_q;
        cnt_d        = cnt_q;
        cur_div_d    = cur_div_q;
        start_div_d  = start_div_q;
        run_div_d    = run_div_q;
        steps_left_d = steps_left_q;
        coils_d      = coils_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        dir_d        = dir_q;
        half_d       = half_q;

        case (state_q)
            ST_IDLE: begin
                // abort is meaningless while idle, so a simultaneous command still wins.
                if (cmd_valid) begin
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        dir_d        = cmd_dir;
                        half_d       = half_step;
                        run_div_d    = run_eff;
                        start_div_d  = start_eff;
                        cur_div_d    = start_eff;
                        steps_left_d = cmd_steps;
                        cnt_d        = '0;
                        ramp_d       = '0;
                        busy_d       = 1'b1;
                        state_d      = ST_ACCEL;
                    end
                end
            end
            default: begin
                if (abort) begin
                    // Abort beats a coincident step: nothing moves on this edge.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (step_fire) begin
                    cnt_d        = '0;
                    phase_d      = phase_nxt;
                    coils_d      = phase_pat(phase_nxt);
                    steps_left_d = steps_new;
                    if (steps_new == '0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        case (state_q)
                            ST_ACCEL: begin
                                if (accel_near_end) begin
                                    // Peak period is repeated once so the triangle is symmetric.
                                    state_d = ST_DECEL;
                                end else begin
                                    ramp_d = ramp_q + ONE_S;
                                    if (accel_room) begin
                                        cur_div_d = cur_div_q - DELTA;
                                    end else begin
                                        cur_div_d = run_div_q;
                                        state_d   = ST_CRUISE;
                                    end
                                end
                            end
                            ST_CRUISE: begin
                                if (cruise_near_end) begin
                                    state_d   = ST_DECEL;
                                    cur_div_d = decel_div;
                                end
                            end
                            default: begin
                                cur_div_d = decel_div;
                            end
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + ONE_D;
                end
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= 3'd1;
            ramp_q       <= '0;
            cnt_q        <= '0;
            cur_div_q    <= '0;
            start_div_q  <= '0;
            run_div_q    <= '0;
            steps_left_q <= '0;
            coils_q      <= 4'b0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dir_q        <= 1'b0;
            half_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            ramp_q       <= ramp_d;
            cnt_q        <= cnt_d;
            cur_div_q    <= cur_div_d;
            start_div_q  <= start_div_d;
            run_div_q    <= run_div_d;
            steps_left_q <= steps_left_d;
            coils_q      <= coils_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dir_q        <= dir_d;
            half_q       <= half_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign coils      = coils_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign steps_left = steps_left_q;
    assign cur_div    = cur_div_q;

endmodule

// File: tb/tb_stepper_ramp_controller.sv
// Purpose    : scoreboard bench for stepper_ramp_controller.
// Latency    : expected steps/done are queued at accept and retired as the DUT produces them.
// Backpressure: commands are only driven while cmd_ready is expected high.
module tb_stepper_ramp_controller;

    localparam int DIV_W  = 16;
    localparam int STEP_W = 16;

    logic              in_clk        = 1'b0;
    logic              reset_n       = 1'b0;
    logic              cmd_valid     = 1'b0;
    logic [STEP_W-1:0] cmd_steps     = '0;
    logic              cmd_dir       = 1'b0;
    logic [DIV_W-1:0]  cmd_start_div = '0;
    logic [DIV_W-1:0]  cmd_run_div   = '0;
    logic              half_step     = 1'b0;
    logic              abort         = 1'b0;
    logic              cmd_ready;
    logic [3:0]        coils;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_left;
    logic [DIV_W-1:0]  cur_div;

    stepper_ramp_controller #(
        .DIV_W(DIV_W),
        .STEP_W(STEP_W),
        .ACCEL_DELTA(20)
    ) dut (
        .in_clk(in_clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps),
        .cmd_dir(cmd_dir),
        .cmd_start_div(cmd_start_div),
        .cmd_run_div(cmd_run_div),
        .half_step(half_step),
        .abort(abort),
        .coils(coils),
        .busy(busy),
        .done(done),
        .steps_left(steps_left),
        .cur_div(cur_div)
    );

    always #5 in_clk = ~in_clk;

    int cyc = 0;
    always @(posedge in_clk) cyc++;

    typedef struct {
        int         gap;
        logic [3:0] coils;
        int         sl;
        int         div;
    } step_exp_t;

    step_exp_t  step_q[$];
    int         done_q[$];
    int         gq[$];
    int         n_vec    = 0;
    int         n_bad    = 0;
    int         last_evt = 0;
    int         acc_cyc  = 0;
    int         tb_idx   = 1;
    logic [3:0] pat_tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                4'b0010, 4'b0011, 4'b0001, 4'b1001};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor: a step is a decrement of steps_left across an edge where busy was high.
    logic [STEP_W-1:0] prev_sl   = '0;
    logic              prev_busy = 1'b0;
    logic              prev_done = 1'b0;
    always @(negedge in_clk) begin
        step_exp_t e;
        if (reset_n) begin
            if (prev_busy && prev_sl != '0 && steps_left == prev_sl - 1'b1) begin
                if (step_q.size() == 0) begin
                    check_val("extra_step", 1, 0);
                end else begin
                    e = step_q.pop_front();
                    check_val("step_gap", cyc - last_evt, e.gap);
                    check_val("step_coils", {28'd0, coils}, {28'd0, e.coils});
                    check_val("step_steps_left", {16'd0, steps_left}, e.sl);
                    check_val("step_cur_div", {16'd0, cur_div}, e.div);
                end
                last_evt = cyc;
            end
            if (done) begin
                if (done_q.size() == 0) check_val("extra_done", 1, 0);
                else                    check_val("done_cyc", cyc, done_q.pop_front());
                if (prev_done) check_val("done_width", 1, 0);
            end
        end
        prev_sl   = steps_left;
        prev_busy = busy;
        prev_done = done;
    end

    task automatic send_cmd(input int steps, input bit dir, input int sdiv, input int rdiv, input bit half);
        @(negedge in_clk);
        #1;
        check_val("cmd_ready", {31'd0, cmd_ready}, 1);
        cmd_valid     = 1'b1;
        cmd_steps     = STEP_W'(steps);
        cmd_dir       = dir;
        cmd_start_div = DIV_W'(sdiv);
        cmd_run_div   = DIV_W'(rdiv);
        half_step     = half;
        @(posedge in_clk);
        #1;
        cmd_valid = 1'b0;
        acc_cyc   = cyc;
        last_evt  = cyc;
    endtask

    // Queue the first k of `total` steps using the interval list in gq; the period
    // after each step is the next interval, and the final step leaves it untouched.
    task automatic push_steps(input bit half, input bit dir, input int total, input int k);
        int sum = 0;
        for (int i = 0; i < k; i++) begin
            step_exp_t e;
            int inc;
            inc    = (half || (tb_idx % 2 == 0)) ? 1 : 2;
            tb_idx = dir ? (tb_idx + inc) % 8 : (tb_idx + 8 - inc) % 8;
            e.gap   = gq[i];
            e.coils = pat_tbl[tb_idx];
            e.sl    = total - 1 - i;
            e.div   = gq[(i + 1 < total) ? i + 1 : i];
            sum += gq[i];
            step_q.push_back(e);
        end
        if (k == total) done_q.push_back(acc_cyc + sum);
    endtask

    task automatic wait_drain(input int budget, input bit steps_only);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge in_clk);
            #2;
            ok = (step_q.size() == 0) && (steps_only || done_q.size() == 0);
        end
        if (!ok) begin
            check_val("timeout_pending", step_q.size() + done_q.size(), 0);
            step_q.delete();
            done_q.delete();
        end
    endtask

    task automatic pulse_reset();
        @(negedge in_clk);
        #1;
        reset_n = 1'b0;
        @(negedge in_clk);
        #1;
        reset_n = 1'b1;
        tb_idx  = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_coils"}, {28'd0, coils}, 0);
        check_val({tag, "_busy"}, {31'd0, busy}, 0);
        check_val({tag, "_done"}, {31'd0, done}, 0);
        check_val({tag, "_steps_left"}, {16'd0, steps_left}, 0);
        check_val({tag, "_cur_div"}, {16'd0, cur_div}, 0);
    endtask

    initial begin
        logic [3:0] c0;

        // Reset state
        repeat (3) @(posedge in_clk);
        #1;
        check_reset_outputs("rst");
        check_val("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        @(negedge in_clk);
        #1;
        reset_n = 1'b1;

        // Full-step ramp, forward
        send_cmd(10, 1'b1, 100, 40, 1'b0);
        gq = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
        push_steps(1'b0, 1'b1, 10, 10);
        wait_drain(800, 1'b0);
        check_val("ramp_idle_busy", {31'd0, busy}, 0);

        // Half-step reverse from the reset phase index
        pulse_reset();
        send_cmd(8, 1'b0, 5, 5, 1'b1);
        gq = '{5, 5, 5, 5, 5, 5, 5, 5};
        push_steps(1'b1, 1'b0, 8, 8);
        wait_drain(100, 1'b0);
        check_val("half_hold_coils", {28'd0, coils}, 32'hC);

        // One half step onto an even index, then full steps must realign to odd
        send_cmd(1, 1'b1, 5, 5, 1'b1);
        gq = '{5};
        push_steps(1'b1, 1'b1, 1, 1);
        wait_drain(20, 1'b0);
        send_cmd(2, 1'b1, 5, 5, 1'b0);
        gq = '{5, 5};
        push_steps(1'b0, 1'b1, 2, 2);
        wait_drain(30, 1'b0);

        // Triangle profile
        send_cmd(4, 1'b1, 100, 10, 1'b0);
        gq = '{100, 80, 80, 100};
        push_steps(1'b0, 1'b1, 4, 4);
        wait_drain(400, 1'b0);

        // Zero-step command
        c0 = coils;
        send_cmd(0, 1'b1, 100, 40, 1'b0);
        done_q.push_back(acc_cyc);
        @(negedge in_clk);
        #1;
        check_val("zero_busy", {31'd0, busy}, 0);
        check_val("zero_cmd_ready", {31'd0, cmd_ready}, 1);
        check_val("zero_coils", {28'd0, coils}, {28'd0, c0});
        wait_drain(5, 1'b0);

        // run_div above start_div is clamped
        send_cmd(3, 1'b1, 50, 200, 1'b0);
        gq = '{50, 50, 50};
        push_steps(1'b0, 1'b1, 3, 3);
        wait_drain(300, 1'b0);

        // Abort after the third step
        send_cmd(10, 1'b1, 100, 40, 1'b0);
        gq = '{100, 80, 60, 40};
        push_steps(1'b0, 1'b1, 10, 3);
        wait_drain(400, 1'b1);
        abort = 1'b1;
        done_q.push_back(cyc + 1);
        @(posedge in_clk);
        #1;
        abort = 1'b0;
        wait_drain(10, 1'b0);
        check_val("abort_steps_left", {16'd0, steps_left}, 7);
        check_val("abort_busy", {31'd0, busy}, 0);
        check_val("abort_coils", {28'd0, coils}, {28'd0, pat_tbl[tb_idx]});
        check_val("abort_cmd_ready", {31'd0, cmd_ready}, 1);
        repeat (150) @(negedge in_clk);
        #1;
        check_val("abort_frozen_steps", {16'd0, steps_left}, 7);
        check_val("abort_frozen_coils", {28'd0, coils}, {28'd0, pat_tbl[tb_idx]});

        // Reset pulse while cruising
        send_cmd(10, 1'b1, 100, 40, 1'b0);
        gq = '{100, 80, 60, 40};
        push_steps(1'b0, 1'b1, 10, 3);
        wait_drain(400, 1'b1);
        repeat (5) @(negedge in_clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge in_clk);
        #1;
        reset_n = 1'b1;
        tb_idx  = 1;
        @(posedge in_clk);
        #1;
        check_val("midrst_cmd_ready", {31'd0, cmd_ready}, 1);
        check_val("midrst_busy_after", {31'd0, busy}, 0);
        wait_drain(5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
